// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: serialises core and host accesses onto one data memory.
// Winner's command is registered onto mem_*, strobed for one cycle (write)
// or READ_LATENCY cycles (read), then acked to the owner for one cycle.
module dmem_arbiter #(
  parameter int DATA_W        = 8,
  parameter int D_ADDR_W      = 12,
  parameter int READ_LATENCY  = 1,
  parameter int HOST_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [D_ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic                core_ack,
  output logic [DATA_W-1:0]   core_rdata,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [D_ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic                host_ack,
  output logic [DATA_W-1:0]   host_rdata,
  output logic [D_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_write_enable,
  output logic                mem_output_enable,
  input  logic [DATA_W-1:0]   mem_rdata
);

  // state  | meaning
  // IDLE   | no transaction; requests sampled and arbitrated here
  // ACCESS | memory strobe active: 1 cycle for write, READ_LATENCY for read
  // RESP   | one-cycle ack to owner; requests are not sampled
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("dmem_arbiter: READ_LATENCY must be in 1..4");
  end

  localparam bit         HOST_WINS_TIE = (HOST_PRIORITY != 0);
  // Down-counter load: the read finishes when it reaches zero.
  localparam logic [1:0] LAT_LOAD      = 2'(READ_LATENCY - 1);

  state_t                state;
  logic [1:0]            lat_cnt;
  logic                  owner_host;
  logic                  last_owner_host;
  logic                  cmd_we;

  logic                  grant_host;
  logic                  sel_we;
  logic [D_ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  // Pick the winner and mux its command; only consumed in IDLE.
  always_comb begin
    grant_host = 1'b0;
    if (host_req && !core_req) begin
      grant_host = 1'b1;
    end else if (host_req && core_req) begin
      grant_host = HOST_WINS_TIE ? 1'b1 : !last_owner_host;
    end
    sel_we    = grant_host ? host_we    : core_we;
    sel_addr  = grant_host ? host_addr  : core_addr;
    sel_wdata = grant_host ? host_wdata : core_wdata;
  end

  // Arbitration FSM with registered memory strobes, acks and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      lat_cnt           <= '0;
      owner_host        <= 1'b0;
      last_owner_host   <= 1'b1;
      cmd_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      mem_write_enable  <= 1'b0;
      mem_output_enable <= 1'b0;
      core_ack          <= 1'b0;
      host_ack          <= 1'b0;
      core_rdata        <= '0;
      host_rdata        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req || host_req) begin
            owner_host      <= grant_host;
            last_owner_host <= grant_host;
            cmd_we          <= sel_we;
            mem_addr        <= sel_addr;
            mem_wdata       <= sel_wdata;
            if (sel_we) begin
              mem_write_enable <= 1'b1;
            end else begin
              mem_output_enable <= 1'b1;
              lat_cnt           <= LAT_LOAD;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cmd_we) begin
            mem_write_enable <= 1'b0;
            core_ack         <= !owner_host;
            host_ack         <= owner_host;
            state            <= RESP;
          end else if (lat_cnt == 2'd0) begin
            mem_output_enable <= 1'b0;
            if (owner_host) begin
              host_rdata <= mem_rdata;
            end else begin
              core_rdata <= mem_rdata;
            end
            core_ack <= !owner_host;
            host_ack <= owner_host;
            state    <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          core_ack <= 1'b0;
          host_ack <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter: two arbiter instances (RL=3/round-robin, RL=4/host
// priority) against a behavioural memory; expected transactions are queued
// by the stimulus and consumed by a negedge monitor.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;

  typedef struct packed {
    logic          host;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n      [2];
  logic          core_req   [2];
  logic          core_we    [2];
  logic [AW-1:0] core_addr  [2];
  logic [DW-1:0] core_wdata [2];
  logic          core_ack   [2];
  logic [DW-1:0] core_rdata [2];
  logic          host_req   [2];
  logic          host_we    [2];
  logic [AW-1:0] host_addr  [2];
  logic [DW-1:0] host_wdata [2];
  logic          host_ack   [2];
  logic [DW-1:0] host_rdata [2];
  logic [AW-1:0] mem_addr   [2];
  logic [DW-1:0] mem_wdata  [2];
  logic          mem_we     [2];
  logic          mem_oe     [2];
  logic [DW-1:0] mem_rdata  [2];

  logic [DW-1:0] mem_model [2][4096];
  exp_t          exp_q     [2][$];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            en_cnt   [2];
  int            last_en  [2];
  logic [DW-1:0] rd_core  [2];
  logic [DW-1:0] rd_host  [2];

  logic [DW-1:0] core_vals [3] = '{8'h11, 8'h22, 8'h33};
  logic [DW-1:0] host_vals [3] = '{8'hA1, 8'hA2, 8'hA3};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(
      .DATA_W(DW), .D_ADDR_W(AW),
      .READ_LATENCY(g == 0 ? 3 : 4), .HOST_PRIORITY(g)
    ) u_dut (
      .clk(clk), .reset_n(rst_n[g]),
      .core_req(core_req[g]), .core_we(core_we[g]), .core_addr(core_addr[g]),
      .core_wdata(core_wdata[g]), .core_ack(core_ack[g]), .core_rdata(core_rdata[g]),
      .host_req(host_req[g]), .host_we(host_we[g]), .host_addr(host_addr[g]),
      .host_wdata(host_wdata[g]), .host_ack(host_ack[g]), .host_rdata(host_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_write_enable(mem_we[g]), .mem_output_enable(mem_oe[g]),
      .mem_rdata(mem_rdata[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory; read data is poisoned while the read enable is low.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (mem_we[k] === 1'b1) mem_model[k][mem_addr[k]] <= mem_wdata[k];
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      mem_rdata[k] = (mem_oe[k] === 1'b1) ? mem_model[k][mem_addr[k]] : 8'hEE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: checks strobes against the queue head and pops on every ack.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rst_n[k] !== 1'b1) begin
        en_cnt[k]  = 0;
        rd_core[k] = '0;
        rd_host[k] = '0;
      end else begin
        if (mem_we[k] === 1'b1 && mem_oe[k] === 1'b1)
          check($sformatf("i%0d_enable_overlap", k), 1, 0);
        if (mem_we[k] === 1'b1 || mem_oe[k] === 1'b1) begin
          if (en_cnt[k] == 0) begin
            if (exp_q[k].size() == 0) begin
              check($sformatf("i%0d_unexpected_grant", k), 1, 0);
            end else begin
              check($sformatf("i%0d_grant_addr", k), 32'(mem_addr[k]), 32'(exp_q[k][0].addr));
              check($sformatf("i%0d_grant_we", k), 32'(mem_we[k]), 32'(exp_q[k][0].we));
              if (exp_q[k][0].we)
                check($sformatf("i%0d_grant_wdata", k), 32'(mem_wdata[k]), 32'(exp_q[k][0].wdata));
            end
          end
          en_cnt[k]++;
          last_en[k] = cyc;
        end
        if (core_ack[k] === 1'b1 || host_ack[k] === 1'b1) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("i%0d_unexpected_ack", k), 1, 0);
          end else begin
            e = exp_q[k].pop_front();
            check($sformatf("i%0d_ack_port", k), 32'({core_ack[k], host_ack[k]}),
                  e.host ? 32'h1 : 32'h2);
            check($sformatf("i%0d_strobe_cycles", k), 32'(en_cnt[k]),
                  e.we ? 32'd1 : (k == 0 ? 32'd3 : 32'd4));
            check($sformatf("i%0d_ack_delay", k), 32'(cyc - last_en[k]), 32'd1);
            if (!e.we) begin
              if (e.host) rd_host[k] = e.rdata;
              else        rd_core[k] = e.rdata;
            end
            check($sformatf("i%0d_core_rdata", k), 32'(core_rdata[k]), 32'(rd_core[k]));
            check($sformatf("i%0d_host_rdata", k), 32'(host_rdata[k]), 32'(rd_host[k]));
          end
          en_cnt[k] = 0;
        end
      end
    end
  end

  task automatic push(input int k, input bit host, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    exp_t e;
    e.host = host; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
    exp_q[k].push_back(e);
  endtask

  // Raise a request, wait (bounded) for its ack, optionally keep req high.
  task automatic drive(input int k, input bit host, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input bit hold, output int ack_cyc);
    int n;
    if (host) begin
      host_we[k] = we; host_addr[k] = a; host_wdata[k] = wd; host_req[k] = 1'b1;
    end else begin
      core_we[k] = we; core_addr[k] = a; core_wdata[k] = wd; core_req[k] = 1'b1;
    end
    ack_cyc = -1;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if ((host ? host_ack[k] : core_ack[k]) === 1'b1) begin
        ack_cyc = cyc;
        break;
      end
      n++;
    end
    if (ack_cyc < 0) check($sformatf("i%0d_ack_timeout_%s", k, host ? "host" : "core"), 1, 0);
    if (!hold) begin
      if (host) host_req[k] = 1'b0;
      else      core_req[k] = 1'b0;
    end
  endtask

  task automatic check_zero(input int k, input string tag);
    check($sformatf("i%0d_%s_strobes_acks", k, tag),
          32'({mem_we[k], mem_oe[k], core_ack[k], host_ack[k]}), 32'd0);
    check($sformatf("i%0d_%s_mem_addr", k, tag), 32'(mem_addr[k]), 32'd0);
    check($sformatf("i%0d_%s_mem_wdata", k, tag), 32'(mem_wdata[k]), 32'd0);
    check($sformatf("i%0d_%s_core_rdata", k, tag), 32'(core_rdata[k]), 32'd0);
    check($sformatf("i%0d_%s_host_rdata", k, tag), 32'(host_rdata[k]), 32'd0);
  endtask

  initial begin
    int   t0, t1, t2, n;
    exp_t e_drop;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b1;
      core_req[k] = 1'b0; core_we[k] = 1'b0; core_addr[k] = '0; core_wdata[k] = '0;
      host_req[k] = 1'b0; host_we[k] = 1'b0; host_addr[k] = '0; host_wdata[k] = '0;
    end
    #2;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Instance 0: core write, then host read back of the same location.
    push(0, 0, 1, 12'h010, 8'h5A, 8'h00);
    drive(0, 0, 1, 12'h010, 8'h5A, 0, t0);
    push(0, 1, 0, 12'h010, 8'h00, 8'h5A);
    drive(0, 1, 0, 12'h010, 8'h00, 0, t0);

    // Preload through the host port (also leaves last owner = host).
    for (int i = 0; i < 3; i++) begin
      push(0, 1, 1, 12'(12'h100 + i), core_vals[i], 8'h00);
      drive(0, 1, 1, 12'(12'h100 + i), core_vals[i], 0, t0);
      push(0, 1, 1, 12'(12'h200 + i), host_vals[i], 8'h00);
      drive(0, 1, 1, 12'(12'h200 + i), host_vals[i], 0, t0);
    end

    // Continuous contention, round-robin: core, host, core, host, core, host.
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 0, 12'(12'h100 + i), 8'h00, core_vals[i]);
      push(0, 1, 0, 12'(12'h200 + i), 8'h00, host_vals[i]);
    end
    fork
      begin
        int tc;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 12'(12'h100 + i), 8'h00, (i < 2), tc);
      end
      begin
        int th;
        for (int j = 0; j < 3; j++) drive(0, 1, 0, 12'(12'h200 + j), 8'h00, (j < 2), th);
      end
    join

    // Back-to-back core writes with req held: one grant every 3 cycles.
    push(0, 0, 1, 12'h020, 8'hC0, 8'h00);
    push(0, 0, 1, 12'h021, 8'hC1, 8'h00);
    push(0, 0, 1, 12'h022, 8'hC2, 8'h00);
    drive(0, 0, 1, 12'h020, 8'hC0, 1, t0);
    drive(0, 0, 1, 12'h021, 8'hC1, 1, t1);
    drive(0, 0, 1, 12'h022, 8'hC2, 0, t2);
    check("i0_b2b_gap1", 32'(t1 - t0), 32'd3);
    check("i0_b2b_gap2", 32'(t2 - t1), 32'd3);
    push(0, 0, 0, 12'h021, 8'h00, 8'hC1);
    drive(0, 0, 0, 12'h021, 8'h00, 0, t0);

    // Instance 1: host priority on simultaneous writes to one address.
    push(1, 1, 1, 12'h030, 8'h77, 8'h00);
    push(1, 0, 1, 12'h030, 8'h66, 8'h00);
    fork
      begin
        int th;
        drive(1, 1, 1, 12'h030, 8'h77, 0, th);
      end
      begin
        int tc;
        drive(1, 0, 1, 12'h030, 8'h66, 0, tc);
      end
    join
    check("i1_mem_after_prio", 32'(mem_model[1][12'h030]), 32'h66);

    // Reset in the middle of a READ_LATENCY=4 read.
    push(1, 0, 0, 12'h030, 8'h00, 8'h66);
    core_we[1] = 1'b0; core_addr[1] = 12'h030; core_wdata[1] = 8'h00; core_req[1] = 1'b1;
    n = 0;
    while (mem_oe[1] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("i1_abort_read_started", 32'(mem_oe[1]), 32'd1);
    @(negedge clk);
    #2;
    rst_n[1] = 1'b0;
    core_req[1] = 1'b0;
    #1;
    check_zero(1, "abort");
    e_drop = exp_q[1].pop_front();
    repeat (4) @(negedge clk);
    check("i1_abort_no_ack", 32'({core_ack[1], host_ack[1]}), 32'd0);
    rst_n[1] = 1'b1;
    @(negedge clk);
    push(1, 0, 0, 12'h030, 8'h00, 8'h66);
    drive(1, 0, 0, 12'h030, 8'h00, 0, t0);

    repeat (3) @(negedge clk);
    check("i0_queue_drained", 32'(exp_q[0].size()), 32'd0);
    check("i1_queue_drained", 32'(exp_q[1].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data memory between two requesters: the CPU core data port and a host/debug port (program loader, bench probe). It sits between the core's data memory interface and the physical data memory, and owns the memory's enables. It serialises transactions through a small FSM with a fixed-latency read wait. It returns a one-cycle acknowledge with captured read data to the winning requester.

## Interface
- DATA_W, 8, data width
- D_ADDR_W, 12, data address width
- READ_LATENCY, 1, cycles `mem_output_enable` is held before `mem_rdata` is sampled; legal 1..4, elaboration error otherwise
- HOST_PRIORITY, 0, 0 = round-robin on contention, 1 = host always wins contention

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- core_req  in  1  core transaction request, held until `core_ack`
- core_we  in  1  1 = write, 0 = read
- core_addr  in  D_ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  DATA_W  last read data returned to core
- host_req, host_we, host_addr, host_wdata, host_ack, host_rdata: same as core_* for host port
- mem_addr  out  D_ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered memory write data
- mem_write_enable  out  1  memory write strobe
- mem_output_enable  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick a winner, latch its we/addr/wdata into `mem_*` registers and latch the owner, then go to ACCESS. If no req is high, stay in IDLE.
- Arbitration when only one req is high: that requester wins.
- Arbitration when both are high, HOST_PRIORITY=1: host wins.
- Arbitration when both are high, HOST_PRIORITY=0: the requester that is not `last_owner` wins.
  - `last_owner` updates on every grant.
  - `last_owner` resets to host, so the core wins the first tie.
- ACCESS, write: `mem_write_enable`=1 for exactly one cycle, then go to RESP.
- ACCESS, read:
  - `mem_output_enable`=1 for READ_LATENCY consecutive cycles, counted by a latency counter.
  - At the end of the last cycle, `mem_rdata` is captured into the owner's rdata register, then go to RESP.
- RESP: the owner's ack = 1 for one cycle, then go to IDLE. No grant is made in RESP.
- Requester rules:
  - Command inputs must be stable from req rise until ack.
  - req is sampled only in IDLE. A req still high in the IDLE after ack is a new transaction.
  - The loser's req stays pending and is granted on the next IDLE.
- rdata: each port's rdata holds its last completed read. Writes and the other port's reads do not change it.
- `mem_addr`/`mem_wdata` hold the last latched command outside ACCESS.
- `mem_write_enable` and `mem_output_enable` are 0 outside ACCESS and never high together.

## Timing
- Reset (asynchronous, any state):
  - FSM returns to IDLE and the latency counter goes to 0.
  - All outputs go to 0; `last_owner` = host.
  - Any in-flight transaction is dropped with no ack; the requester reissues it.
- Write, req high at edge E0:
  - ACCESS in cycle E0..E1 with `mem_write_enable`=1.
  - ack in E1..E2.
  - IDLE from E2.
  - Total: ack 2 cycles after grant edge, 3 cycles per write.
- Read: ACCESS lasts READ_LATENCY cycles; ack 1+READ_LATENCY cycles after grant edge; 2+READ_LATENCY cycles per read.
- rdata is valid in the ack cycle and held afterwards.
- Both reqs high continuously, HOST_PRIORITY=0: grants strictly alternate, and neither port waits more than one other transaction.
- The ack cycle does not sample req, so a new req asserted in the ack cycle is granted at the following IDLE edge.

## Test plan
- Reset then core write 0x5A to 0x010: `mem_write_enable` for 1 cycle with `mem_addr`=0x010, `mem_wdata`=0x5A; `core_ack` 2 cycles after grant; `host_ack` stays 0.
- READ_LATENCY=3, host read 0x010 with memory returning 0x5A: `mem_output_enable` high 3 cycles; `host_ack` 4 cycles after grant; `host_rdata`=0x5A; `core_rdata` unchanged at 0x00.
- HOST_PRIORITY=0, both ports read continuously for 6 transactions: grant order core, host, core, host, core, host; each port's rdata matches its own address contents.
- HOST_PRIORITY=1, both ports write together: host granted first, core second; memory holds the core value if the addresses are equal.
- Assert reset_n=0 in the middle of a READ_LATENCY=4 read: all outputs 0 immediately, no ack. After release, the reissued read completes normally.
- Back-to-back core writes with req held high: a new grant every 3 cycles; enables never overlap and are never high in IDLE or RESP.
